// File: rtl/card_list_ctrl.sv
// card_list_ctrl: LIFO card list and free list sharing one single-port synchronous RAM
// Ports: clock/resetn (async active-low); req_valid/req_op/req_card/req_ready request side;
// rsp_valid/rsp_err/rsp_card completion pulse; count/empty/full list status;
// mem_addr/mem_wdata/mem_wren/mem_rdata drive the card RAM (rdata valid the cycle after the address edge).
module card_list_ctrl #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = ADDR_W + 6
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [5:0]        req_card,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [5:0]        rsp_card,
  output logic [ADDR_W-1:0] count,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [WORD_W-1:0] mem_rdata
);
  localparam logic [ADDR_W-1:0] NIL = '1;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CAP_M1 = NIL - ONE;
  typedef enum logic [1:0] {INIT, IDLE, RD, WR} state_t;
  state_t state;
  logic [ADDR_W-1:0] list_head, free_head, idx;
  logic [WORD_W-1:0] wdata_q;
  logic [5:0] card_q;
  logic pop_q, clr_q;
  logic [ADDR_W-1:0] rd_next;
  assign rd_next = mem_rdata[WORD_W-1:6];
  // a pop writes back the card it just read, which only arrives during WR
  assign mem_wdata = (state == WR && pop_q) ? {free_head, mem_rdata[5:0]} : wdata_q;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= INIT;
      idx <= '0;
      list_head <= NIL;
      free_head <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_card <= '0;
      mem_addr <= '0;
      mem_wren <= 1'b0;
      wdata_q <= '0;
      card_q <= '0;
      pop_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_card <= '0;
      case (state)
        INIT: begin
          if (idx == NIL) begin
            state <= IDLE;
            req_ready <= 1'b1;
            mem_wren <= 1'b0;
            wdata_q <= '0;
            free_head <= '0;
            list_head <= NIL;
            count <= '0;
            empty <= 1'b1;
            full <= 1'b0;
            rsp_valid <= clr_q;
            clr_q <= 1'b0;
          end else begin
            // idx+1 at the last entry wraps onto NIL, terminating the free list
            mem_wren <= 1'b1;
            mem_addr <= idx;
            wdata_q <= {idx + ONE, 6'b0};
            idx <= idx + ONE;
          end
        end
        IDLE: begin
          if (req_valid) begin
            pop_q <= req_op[0];
            card_q <= req_card;
            if (req_op == 2'b10) begin
              // first INIT write issues right away so clear completes in CAP+1 cycles
              state <= INIT;
              idx <= ONE;
              clr_q <= 1'b1;
              req_ready <= 1'b0;
              mem_wren <= 1'b1;
              mem_addr <= '0;
              wdata_q <= {ONE, 6'b0};
            end else if (req_op == 2'b11 || (req_op == 2'b00 && full) || (req_op == 2'b01 && empty)) begin
              rsp_valid <= 1'b1;
              rsp_err <= 1'b1;
            end else begin
              state <= RD;
              req_ready <= 1'b0;
              mem_addr <= req_op[0] ? list_head : free_head;
            end
          end
        end
        RD: begin
          state <= WR;
          mem_wren <= 1'b1;
          wdata_q <= {list_head, card_q};
        end
        WR: begin
          state <= IDLE;
          mem_wren <= 1'b0;
          wdata_q <= '0;
          req_ready <= 1'b1;
          rsp_valid <= 1'b1;
          if (pop_q) begin
            free_head <= list_head;
            list_head <= rd_next;
            count <= count - ONE;
            empty <= count == ONE;
            full <= 1'b0;
            rsp_card <= mem_rdata[5:0];
          end else begin
            list_head <= free_head;
            free_head <= rd_next;
            count <= count + ONE;
            empty <= 1'b0;
            full <= count == CAP_M1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_card_list_ctrl.sv
// tb_card_list_ctrl: self-checking bench with stack model and per-cycle compare
module tb_card_list_ctrl;
  logic clock = 1'b0;
  logic resetn = 1'b1;
  logic req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic [5:0] req_card = 6'd0;
  logic req_ready, rsp_valid, rsp_err, empty, full, mem_wren;
  logic [5:0] rsp_card, count, mem_addr;
  logic [11:0] mem_wdata, mem_rdata;
  logic [11:0] ram [64];
  int checks = 0;
  int failures = 0;

  card_list_ctrl dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
    .req_card(req_card), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_card(rsp_card), .count(count), .empty(empty),
    .full(full), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // model: a stack of cards plus the time left until the pending request completes
  logic m_ready = 1'b0, e_valid = 1'b0, e_err = 1'b0;
  logic [5:0] e_card = 6'd0, m_card = 6'd0;
  int m_busy = 64;
  int m_kind = 3;
  logic [5:0] m_stack[$];

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_stack.delete();
      m_busy <= 64;
      m_kind <= 3;
      m_ready <= 1'b0;
      e_valid <= 1'b0;
      e_err <= 1'b0;
      e_card <= 6'd0;
    end else begin
      e_valid <= 1'b0;
      e_err <= 1'b0;
      e_card <= 6'd0;
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_ready <= 1'b1;
          e_valid <= (m_kind != 3);
          if (m_kind == 0) m_stack.push_back(m_card);
          else if (m_kind == 1) begin
            e_card <= m_stack[$];
            m_stack.pop_back();
          end else if (m_kind == 2) m_stack.delete();
        end
      end else if (m_ready && req_valid) begin
        if (req_op == 2'b11 || (req_op == 2'b00 && m_stack.size() == 63) || (req_op == 2'b01 && m_stack.size() == 0)) begin
          e_valid <= 1'b1;
          e_err <= 1'b1;
        end else begin
          m_ready <= 1'b0;
          m_kind <= int'(req_op);
          m_card <= req_card;
          m_busy <= (req_op == 2'b10) ? 63 : 2;
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("req_ready", req_ready, m_ready);
    chk("rsp_valid", rsp_valid, e_valid);
    chk("rsp_err", rsp_err, e_err);
    chk("rsp_card", rsp_card, e_card);
    chk("count", count, m_stack.size());
    chk("empty", empty, m_stack.size() == 0);
    chk("full", full, m_stack.size() == 63);
    if (!mem_wren) chk("wdata_idle", mem_wdata, 0);
  end

  task automatic do_op(input string name, input logic [1:0] op, input logic [5:0] card,
                       input int exp_lat, input logic exp_err, input logic [5:0] exp_card);
    int w, lat;
    bit wr_seen;
    w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clock);
      w++;
    end
    chk({name, "_ready_timeout"}, req_ready, 1);
    req_valid = 1'b1;
    req_op = op;
    req_card = card;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_op = 2'b11;
    req_card = ~card;
    lat = 0;
    wr_seen = 0;
    while (lat < 100) begin
      @(negedge clock);
      lat++;
      if (mem_wren) wr_seen = 1;
      if (rsp_valid) break;
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_err"}, rsp_err, exp_err);
    chk({name, "_card"}, rsp_card, exp_card);
    if (exp_err) chk({name, "_no_ram"}, wr_seen, 0);
  endtask

  initial begin
    int nw, rdy_at, w;
    bit addr_ok, seen_rsp;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_ready", req_ready, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    resetn = 1'b1;
    nw = 0;
    rdy_at = -1;
    addr_ok = 1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clock);
      if (mem_wren) begin
        if (mem_addr != 6'(nw)) addr_ok = 0;
        nw++;
      end
      if (req_ready && rdy_at < 0) rdy_at = i;
    end
    chk("init_writes", nw, 63);
    chk("init_addrs", addr_ok, 1);
    chk("init_ready_cycle", rdy_at, 63);
    chk("init_word62_next", ram[62][11:6], 63);
    chk("init_word0_next", ram[0][11:6], 1);
    chk("init_count", count, 0);

    do_op("push05", 2'b00, 6'h05, 3, 0, 6'h00);
    do_op("push1a", 2'b00, 6'h1A, 3, 0, 6'h00);
    do_op("push33", 2'b00, 6'h33, 3, 0, 6'h00);
    chk("count3", count, 3);
    do_op("pop33", 2'b01, 6'h00, 3, 0, 6'h33);
    do_op("pop1a", 2'b01, 6'h00, 3, 0, 6'h1A);
    do_op("pop05", 2'b01, 6'h00, 3, 0, 6'h05);
    chk("count0", count, 0);
    chk("empty0", empty, 1);

    do_op("pop_empty", 2'b01, 6'h00, 1, 1, 6'h00);
    chk("pop_empty_count", count, 0);
    do_op("op11", 2'b11, 6'h2A, 1, 1, 6'h00);

    for (int i = 0; i < 63; i++) do_op("fill", 2'b00, 6'(i), 3, 0, 6'h00);
    chk("full_flag", full, 1);
    chk("full_count", count, 63);
    do_op("push_full", 2'b00, 6'h3F, 1, 1, 6'h00);
    do_op("pop_after_full", 2'b01, 6'h00, 3, 0, 6'd62);
    chk("not_full", full, 0);

    do_op("clear", 2'b10, 6'h00, 64, 0, 6'h00);
    chk("clear_count", count, 0);
    do_op("pop_after_clear", 2'b01, 6'h00, 1, 1, 6'h00);
    do_op("push2c", 2'b00, 6'h2C, 3, 0, 6'h00);
    do_op("pop2c", 2'b01, 6'h00, 3, 0, 6'h2C);

    do_op("push_a", 2'b00, 6'h21, 3, 0, 6'h00);
    do_op("push_b", 2'b00, 6'h12, 3, 0, 6'h00);
    req_valid = 1'b1;
    req_op = 2'b00;
    req_card = 6'h11;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1 chk("wr_cycle_wren", mem_wren, 1);
    #1 resetn = 1'b0;
    #1;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_count", count, 0);
    chk("abort_empty", empty, 1);
    chk("abort_wren", mem_wren, 0);
    chk("abort_ready", req_ready, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_wdata", mem_wdata, 0);
    @(negedge clock);
    resetn = 1'b1;
    w = 0;
    seen_rsp = 0;
    while (!req_ready && w < 200) begin
      @(negedge clock);
      if (rsp_valid) seen_rsp = 1;
      w++;
    end
    chk("reinit_ready", req_ready, 1);
    chk("reinit_no_rsp", seen_rsp, 0);
    chk("reinit_count", count, 0);
    do_op("pop_after_reinit", 2'b01, 6'h00, 1, 1, 6'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
